// File: rtl/alu_ctrl_pkg.sv
// ALU control codes shared between ALU_Control and the EX-stage execute unit,
// plus the execute unit's state encoding.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_XOR  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_MUL  = 4'b0101;
  localparam logic [3:0] ALU_ADDI = 4'b0110;
  localparam logic [3:0] ALU_SRAI = 4'b0111;
  localparam logic [3:0] ALU_LW   = 4'b1000;
  localparam logic [3:0] ALU_BEQ  = 4'b1001;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_MUL  = 1'b1;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= ALU_BEQ;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH clocks per
// product. done_o is asserted during the final iteration, with result_o = acc_next.
module seq_multiplier
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             busy;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    acc_next = acc;
    if (multiplier[0]) acc_next = acc + multiplicand;
  end

  assign done_o   = busy & (count == CNT_W'(WIDTH - 1));
  assign result_o = acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= 1'b0;
      count        <= '0;
      multiplicand <= '0;
      multiplier   <= '0;
      acc          <= '0;
    end else if (start) begin
      busy         <= 1'b1;
      count        <= '0;
      multiplicand <= a;
      multiplier   <= b;
      acc          <= '0;
    end else if (busy) begin
      if (flush) begin
        busy  <= 1'b0;
        count <= '0;
      end else begin
        acc          <= acc_next;
        multiplicand <= multiplicand << 1;
        multiplier   <= multiplier >> 1;
        count        <= count + CNT_W'(1);
        if (done_o) busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage execute unit: single-cycle ALU ops registered in one cycle, multiply
// handed to seq_multiplier while the pipeline is stalled.
module alu_exec_unit
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             illegal_o
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic               state;
  logic               accept;
  logic               is_mul;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_illegal;
  logic               mul_done;
  logic [WIDTH-1:0]   mul_result;

  assign ready_o = (state == ST_IDLE);
  assign stall_o = (state == ST_MUL);
  assign accept  = valid_i & ready_o & ~flush_i;
  assign is_mul  = (ALUCtrl_i == ALU_MUL);
  assign shamt   = data2_i[SHAMT_W-1:0];

  always_comb begin
    alu_result  = '0;
    alu_illegal = ~is_legal_op(ALUCtrl_i);
    case (ALUCtrl_i)
      ALU_AND:                    alu_result = data1_i & data2_i;
      ALU_XOR:                    alu_result = data1_i ^ data2_i;
      ALU_SLL:                    alu_result = data1_i << shamt;
      ALU_ADD, ALU_ADDI, ALU_LW:  alu_result = data1_i + data2_i;
      ALU_SUB, ALU_BEQ:           alu_result = data1_i - data2_i;
      ALU_SRAI:                   alu_result = WIDTH'($signed(data1_i) >>> shamt);
      default:                    alu_result = '0;
    endcase
  end

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk_i),
    .rst      (rst_i),
    .start    (accept & is_mul),
    .flush    (flush_i),
    .a        (data1_i),
    .b        (data2_i),
    .done_o   (mul_done),
    .result_o (mul_result)
  );

  // A flush during MUL drops the product and leaves data_o/zero_o untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      valid_o   <= 1'b0;
      data_o    <= '0;
      zero_o    <= 1'b0;
      illegal_o <= 1'b0;
    end else begin
      valid_o   <= 1'b0;
      illegal_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state <= ST_MUL;
            end else begin
              data_o    <= alu_result;
              zero_o    <= (alu_result == '0);
              illegal_o <= alu_illegal;
              valid_o   <= 1'b1;
            end
          end
        end
        default: begin
          if (flush_i) begin
            state <= ST_IDLE;
          end else if (mul_done) begin
            data_o  <= mul_result;
            zero_o  <= (mul_result == '0);
            valid_o <= 1'b1;
            state   <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed, table-driven bench for alu_exec_unit with hand-computed expectations
// and hand-written multi-cycle sequences for mul, flush and reset.
module tb_alu_exec_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [3:0]  ALUCtrl_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        flush_i;
  logic        ready_o;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic        zero_o;
  logic        illegal_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_zero;
    logic        exp_illegal;
  } vec_t;

  vec_t vecs[13];

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .flush_i   (flush_i),
    .ready_o   (ready_o),
    .stall_o   (stall_o),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .zero_o    (zero_o),
    .illegal_o (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic exp_valid, input logic [31:0] exp_data,
                             input logic exp_zero, input logic exp_illegal);
    checkVal({name, ".valid"},   {31'b0, valid_o},   {31'b0, exp_valid});
    checkVal({name, ".data"},    data_o,             exp_data);
    checkVal({name, ".zero"},    {31'b0, zero_o},    {31'b0, exp_zero});
    checkVal({name, ".illegal"}, {31'b0, illegal_o}, {31'b0, exp_illegal});
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic fl);
    valid_i   = v;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    flush_i   = fl;
  endtask

  initial begin
    int cycles;
    logic [31:0] held;

    vecs[0]  = '{"add_ovf",  4'b0011, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0};
    vecs[1]  = '{"sub_eq",   4'b0100, 32'd5,         32'd5,         32'h0000_0000, 1'b1, 1'b0};
    vecs[2]  = '{"xor",      4'b0001, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0, 1'b0};
    vecs[3]  = '{"srai",     4'b0111, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1'b0};
    vecs[4]  = '{"and",      4'b0000, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0};
    vecs[5]  = '{"sll",      4'b0010, 32'h0000_0001, 32'd4,         32'h0000_0010, 1'b0, 1'b0};
    vecs[6]  = '{"sll_mask", 4'b0010, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 1'b0, 1'b0};
    vecs[7]  = '{"addi",     4'b0110, 32'd100,       32'hFFFF_FFFF, 32'd99,        1'b0, 1'b0};
    vecs[8]  = '{"lw_addr",  4'b1000, 32'h1000_0000, 32'h0000_0040, 32'h1000_0040, 1'b0, 1'b0};
    vecs[9]  = '{"beq_ne",   4'b1001, 32'd9,         32'd8,         32'd1,         1'b0, 1'b0};
    vecs[10] = '{"sub_wrap", 4'b0100, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[11] = '{"illegal",  4'b1011, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b1, 1'b1};
    vecs[12] = '{"srai_pos", 4'b0111, 32'h7000_0000, 32'd31,        32'h0000_0000, 1'b1, 1'b0};

    // Reset state
    rst_i = 1'b1;
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
    #12;
    checkOutput("reset", 1'b0, 32'h0, 1'b0, 1'b0);
    checkVal("reset.ready", {31'b0, ready_o}, 32'd1);
    checkVal("reset.stall", {31'b0, stall_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Single-cycle ops back to back, one per clock
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      @(negedge clk_i);
      checkOutput(vecs[i].name, 1'b1, vecs[i].exp_data, vecs[i].exp_zero, vecs[i].exp_illegal);
    end
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
    @(negedge clk_i);
    checkOutput("idle_after_table", 1'b0, 32'h0, 1'b1, 1'b0);

    // mul 0xFFFFFFFF*3 with a held add 2+2 behind it
    applyStimulus(1'b1, 4'b0101, 32'hFFFF_FFFF, 32'd3, 1'b0);
    @(negedge clk_i);
    applyStimulus(1'b1, 4'b0011, 32'd2, 32'd2, 1'b0);
    cycles = 0;
    while (stall_o === 1'b1 && cycles < 40) begin
      checkVal("mul.ready_low", {31'b0, ready_o}, 32'd0);
      checkVal("mul.no_valid", {31'b0, valid_o}, 32'd0);
      cycles++;
      @(negedge clk_i);
    end
    checkVal("mul.stall_cycles", cycles, 32'd32);
    checkOutput("mul.result", 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    checkVal("mul.ready_at_done", {31'b0, ready_o}, 32'd1);
    @(negedge clk_i);
    checkOutput("add_after_mul", 1'b1, 32'd4, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);

    // mul 1234*5678 flushed mid-way
    applyStimulus(1'b1, 4'b0101, 32'd1234, 32'd5678, 1'b0);
    @(negedge clk_i);
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge clk_i);
    checkVal("flush.pre_stall", {31'b0, stall_o}, 32'd1);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    checkOutput("flush.mul", 1'b0, 32'd4, 1'b0, 1'b0);
    checkVal("flush.ready", {31'b0, ready_o}, 32'd1);
    checkVal("flush.stall", {31'b0, stall_o}, 32'd0);
    cycles = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (valid_o !== 1'b0) cycles++;
    end
    checkVal("flush.no_late_valid", cycles, 32'd0);

    // Full mul 1234*5678 after the flush
    applyStimulus(1'b1, 4'b0101, 32'd1234, 32'd5678, 1'b0);
    @(negedge clk_i);
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
    cycles = 0;
    while (valid_o !== 1'b1 && cycles < 40) begin
      cycles++;
      @(negedge clk_i);
    end
    checkVal("mul2.latency", cycles, 32'd32);
    checkOutput("mul2.result", 1'b1, 32'd7006652, 1'b0, 1'b0);

    // valid_i together with flush_i is dropped
    held = data_o;
    applyStimulus(1'b1, 4'b0011, 32'd1, 32'd1, 1'b1);
    @(negedge clk_i);
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
    checkOutput("valid_with_flush", 1'b0, held, 1'b0, 1'b0);

    // Async reset mid-mul, then beq 9,9
    applyStimulus(1'b1, 4'b0101, 32'd1234, 32'd5678, 1'b0);
    @(negedge clk_i);
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
    repeat (17) @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("async_rst", 1'b0, 32'h0, 1'b0, 1'b0);
    checkVal("async_rst.ready", {31'b0, ready_o}, 32'd1);
    checkVal("async_rst.stall", {31'b0, stall_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    applyStimulus(1'b1, 4'b1001, 32'd9, 32'd9, 1'b0);
    @(negedge clk_i);
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
    checkOutput("beq_eq", 1'b1, 32'h0, 1'b1, 1'b0);
    cycles = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (valid_o !== 1'b0) cycles++;
    end
    checkVal("post_rst.no_valid", cycles, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
